// File: rtl/bht_update_queue.sv
// In-order speculative branch-metadata queue feeding the tournament predictor's update port.
// Optional statistics counters are enabled with the BHT_UPD_STATS_EN macro.
module bht_update_queue #(
    parameter int DEPTH  = 8,
    parameter int VLEN   = 64,
    parameter int META_W = 20,
    parameter int CNT_W  = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     debug_mode_i,
    input  logic                     pred_valid_i,
    output logic                     pred_ready_o,
    input  logic [VLEN-1:0]          pred_pc_i,
    input  logic                     pred_taken_i,
    input  logic [META_W-1:0]        pred_meta_i,
    input  logic                     resolve_valid_i,
    input  logic [VLEN-1:0]          resolve_pc_i,
    input  logic                     resolve_taken_i,
    output logic                     bht_update_valid_o,
    output logic [VLEN-1:0]          bht_update_pc_o,
    output logic                     bht_update_taken_o,
    output logic [META_W-1:0]        bht_update_meta_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     error_o,
    output logic [CNT_W-1:0]         resolved_cnt_o,
    output logic [CNT_W-1:0]         mispred_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // Handshake: a push transfers when pred_valid_i && pred_ready_o && !flush_i; pred_ready_o
    // comes only from the registered count, so a pop in the same cycle never frees a slot early.
    logic [VLEN-1:0]   pc_mem   [DEPTH];
    logic [META_W-1:0] meta_mem [DEPTH];
    logic [AW-1:0]     rptr;
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr_inc;
    logic [AW:0]       count;
    logic              empty;
    logic              push;
    logic              pop;
    logic              pc_mismatch;

    assign empty        = (count == '0);
    assign pred_ready_o = (count != FULL_CNT);
    assign push         = pred_valid_i && pred_ready_o && !flush_i;
    assign pop          = resolve_valid_i && !empty;
    assign rptr_inc     = rptr + 1'b1;
    assign pc_mismatch  = (resolve_pc_i != pc_mem[rptr]);
    assign count_o      = count;

    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wptr]   <= pred_pc_i;
            meta_mem[wptr] <= pred_meta_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                rptr <= rptr_inc;
            end
            // A flush still lets the same-cycle resolve pop, then empties what remains.
            if (flush_i) begin
                wptr  <= pop ? rptr_inc : rptr;
                count <= '0;
            end else begin
                if (push) begin
                    wptr <= wptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bht_update_valid_o <= 1'b0;
            bht_update_pc_o    <= '0;
            bht_update_taken_o <= 1'b0;
            bht_update_meta_o  <= '0;
            error_o            <= 1'b0;
        end else begin
            bht_update_valid_o <= pop && !debug_mode_i;
            if (pop) begin
                bht_update_pc_o    <= pc_mem[rptr];
                bht_update_taken_o <= resolve_taken_i;
                bht_update_meta_o  <= meta_mem[rptr];
            end
            if ((resolve_valid_i && empty) || (pop && pc_mismatch)) begin
                error_o <= 1'b1;
            end
        end
    end

`ifdef BHT_UPD_STATS_EN
    logic             taken_mem [DEPTH];
    logic [CNT_W-1:0] resolved_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    always_ff @(posedge clk_i) begin
        if (push) begin
            taken_mem[wptr] <= pred_taken_i;
        end
    end

    // Counters saturate rather than wrap so long runs never under-report.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resolved_cnt <= '0;
            mispred_cnt  <= '0;
        end else if (pop) begin
            if (resolved_cnt != '1) begin
                resolved_cnt <= resolved_cnt + 1'b1;
            end
            if ((resolve_taken_i != taken_mem[rptr]) && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + 1'b1;
            end
        end
    end

    assign resolved_cnt_o = resolved_cnt;
    assign mispred_cnt_o  = mispred_cnt;
`else
    logic unused_pred_taken;
    assign unused_pred_taken = pred_taken_i;
    assign resolved_cnt_o    = '0;
    assign mispred_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_bht_update_queue.sv
// Self-checking bench for bht_update_queue: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_bht_update_queue;

    localparam int DEPTH  = 8;
    localparam int VLEN   = 64;
    localparam int META_W = 20;
    localparam int CNT_W  = 32;

    typedef struct {
        logic [VLEN-1:0]   pc;
        logic              taken;
        logic [META_W-1:0] meta;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              flush = 1'b0;
    logic              dbg = 1'b0;
    logic              pred_valid = 1'b0;
    logic [VLEN-1:0]   pred_pc = '0;
    logic              pred_taken = 1'b0;
    logic [META_W-1:0] pred_meta = '0;
    logic              res_valid = 1'b0;
    logic [VLEN-1:0]   res_pc = '0;
    logic              res_taken = 1'b0;

    logic              pred_ready;
    logic              upd_valid;
    logic [VLEN-1:0]   upd_pc;
    logic              upd_taken;
    logic [META_W-1:0] upd_meta;
    logic [3:0]        count;
    logic              error;
    logic [CNT_W-1:0]  resolved_cnt;
    logic [CNT_W-1:0]  mispred_cnt;

    logic              s_ready, s_valid, s_taken, s_error;
    logic [VLEN-1:0]   s_pc;
    logic [META_W-1:0] s_meta;
    logic [3:0]        s_count;
    logic [1:0]        s_resolved, s_mispred;

    // Reference model state
    entry_t            exp_q[$];
    logic              e_valid;
    logic [VLEN-1:0]   e_pc;
    logic              e_taken;
    logic [META_W-1:0] e_meta;
    logic              e_err;
    int unsigned       e_res;
    int unsigned       e_mis;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    bht_update_queue #(.DEPTH(DEPTH), .VLEN(VLEN), .META_W(META_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .debug_mode_i(dbg),
        .pred_valid_i(pred_valid), .pred_ready_o(pred_ready), .pred_pc_i(pred_pc),
        .pred_taken_i(pred_taken), .pred_meta_i(pred_meta),
        .resolve_valid_i(res_valid), .resolve_pc_i(res_pc), .resolve_taken_i(res_taken),
        .bht_update_valid_o(upd_valid), .bht_update_pc_o(upd_pc),
        .bht_update_taken_o(upd_taken), .bht_update_meta_o(upd_meta),
        .count_o(count), .error_o(error),
        .resolved_cnt_o(resolved_cnt), .mispred_cnt_o(mispred_cnt)
    );

    bht_update_queue #(.DEPTH(DEPTH), .VLEN(VLEN), .META_W(META_W), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .debug_mode_i(dbg),
        .pred_valid_i(pred_valid), .pred_ready_o(s_ready), .pred_pc_i(pred_pc),
        .pred_taken_i(pred_taken), .pred_meta_i(pred_meta),
        .resolve_valid_i(res_valid), .resolve_pc_i(res_pc), .resolve_taken_i(res_taken),
        .bht_update_valid_o(s_valid), .bht_update_pc_o(s_pc),
        .bht_update_taken_o(s_taken), .bht_update_meta_o(s_meta),
        .count_o(s_count), .error_o(s_error),
        .resolved_cnt_o(s_resolved), .mispred_cnt_o(s_mispred)
    );

    // ---------------- driver tasks ----------------
    task automatic idle();
        rst = 1'b0; flush = 1'b0; dbg = 1'b0;
        pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0; pred_meta = '0;
        res_valid = 1'b0; res_pc = '0; res_taken = 1'b0;
    endtask

    // Advance the model with the inputs currently applied, then clock the DUT.
    task automatic step();
        bit     room;
        bit     popped;
        entry_t e;
        if (rst) begin
            exp_q.delete();
            e_valid = 0; e_pc = '0; e_taken = 0; e_meta = '0; e_err = 0; e_res = 0; e_mis = 0;
        end else begin
            room   = exp_q.size() < DEPTH;
            popped = res_valid && exp_q.size() > 0;
            e_valid = popped && !dbg;
            if (res_valid && exp_q.size() == 0) e_err = 1;
            if (popped) begin
                e = exp_q.pop_front();
                e_pc = e.pc; e_meta = e.meta; e_taken = res_taken;
                if (res_pc != e.pc) e_err = 1;
                e_res++;
                if (res_taken != e.taken) e_mis++;
            end
            if (flush) exp_q.delete();
            else if (pred_valid && room) begin
                e.pc = pred_pc; e.taken = pred_taken; e.meta = pred_meta;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        idle();
    endtask

    task automatic push_one(input logic [VLEN-1:0] pc, input logic tk, input logic [META_W-1:0] meta);
        idle();
        pred_valid = 1'b1; pred_pc = pc; pred_taken = tk; pred_meta = meta;
        step();
        idle();
    endtask

    task automatic resolve_one(input logic [VLEN-1:0] pc, input logic tk);
        idle();
        res_valid = 1'b1; res_pc = pc; res_taken = tk;
        step();
        idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        push_one(64'h40, 1'b1, 20'h1);
        push_one(64'h44, 1'b0, 20'h2);
        do_reset();
        tests_run++;
        if (count !== 4'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", count); end
        tests_run++;
        if (pred_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got %b want 1", pred_ready); end
        tests_run++;
        if ({upd_valid, upd_taken, upd_pc, upd_meta, error} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs got v=%b t=%b pc=%h meta=%h err=%b want all 0",
                     upd_valid, upd_taken, upd_pc, upd_meta, error);
        end
        tests_run++;
        if ({resolved_cnt, mispred_cnt} !== '0) begin
            tests_failed++; $display("FAIL reset_counters got %0d/%0d want 0/0", resolved_cnt, mispred_cnt);
        end
        step();
        tests_run++;
        if (upd_valid !== 1'b0 || count !== 4'd0) begin
            tests_failed++; $display("FAIL post_reset_idle got v=%b cnt=%0d want v=0 cnt=0", upd_valid, count);
        end
    endtask

    task automatic test_basic();
        logic [VLEN-1:0]   pcs   [3] = '{64'h100, 64'h104, 64'h108};
        logic [META_W-1:0] metas [3] = '{20'h0A5A1, 20'h00002, 20'h00003};
        logic              tks   [3] = '{1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 3; i++) push_one(pcs[i], 1'b1, metas[i]);
        tests_run++;
        if (count !== 4'd3) begin tests_failed++; $display("FAIL basic_count_full got %0d want 3", count); end
        idle();
        for (int i = 0; i < 3; i++) begin
            res_valid = 1'b1; res_pc = pcs[i]; res_taken = tks[i];
            step();
            tests_run++;
            if (upd_valid !== 1'b1 || upd_pc !== pcs[i] || upd_taken !== tks[i] || upd_meta !== metas[i]) begin
                tests_failed++;
                $display("FAIL basic_update%0d got v=%b pc=%h t=%b meta=%h want v=1 pc=%h t=%b meta=%h",
                         i, upd_valid, upd_pc, upd_taken, upd_meta, pcs[i], tks[i], metas[i]);
            end
            tests_run++;
            if (count !== 4'(2 - i)) begin
                tests_failed++; $display("FAIL basic_count%0d got %0d want %0d", i, count, 2 - i);
            end
        end
        idle();
        step();
        tests_run++;
        if (upd_valid !== 1'b0 || error !== 1'b0) begin
            tests_failed++; $display("FAIL basic_tail got v=%b err=%b want 0/0", upd_valid, error);
        end
    endtask

    task automatic test_full_wrap();
        logic [VLEN-1:0] dropped = 64'hBAD0;
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_one(64'h1000 + 64'(4 * i), 1'b0, 20'(i));
        tests_run++;
        if (pred_ready !== 1'b0 || count !== 4'd8) begin
            tests_failed++; $display("FAIL full_state got ready=%b cnt=%0d want 0/8", pred_ready, count);
        end
        idle();
        pred_valid = 1'b1; pred_pc = dropped; pred_meta = 20'hFFFFF;
        res_valid = 1'b1; res_pc = exp_q[0].pc; res_taken = 1'b1;
        step();
        tests_run++;
        if (count !== 4'd7 || upd_pc !== 64'h1000) begin
            tests_failed++; $display("FAIL full_push_drop got cnt=%0d pc=%h want 7/1000", count, upd_pc);
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            pred_valid = 1'b1; pred_pc = 64'h2000 + 64'(4 * i); pred_meta = 20'(16 + i);
            res_valid = 1'b1; res_pc = exp_q[0].pc; res_taken = i[0];
            step();
            tests_run++;
            if (upd_valid !== e_valid || upd_pc !== e_pc || upd_meta !== e_meta || count !== 4'(exp_q.size())) begin
                tests_failed++;
                $display("FAIL wrap_step%0d got v=%b pc=%h meta=%h cnt=%0d want v=%b pc=%h meta=%h cnt=%0d",
                         i, upd_valid, upd_pc, upd_meta, count, e_valid, e_pc, e_meta, exp_q.size());
            end
        end
        while (exp_q.size() > 0) begin
            resolve_one(exp_q[0].pc, 1'b0);
            tests_run++;
            if (upd_valid !== 1'b1 || upd_pc !== e_pc || upd_pc === dropped || upd_meta !== e_meta) begin
                tests_failed++;
                $display("FAIL drain got v=%b pc=%h meta=%h want v=1 pc=%h meta=%h", upd_valid, upd_pc, upd_meta, e_pc, e_meta);
            end
        end
        tests_run++;
        if (count !== 4'd0 || error !== 1'b0) begin
            tests_failed++; $display("FAIL drain_end got cnt=%0d err=%b want 0/0", count, error);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 4; i++) push_one(64'h300 + 64'(4 * i), 1'b1, 20'(32 + i));
        idle();
        flush = 1'b1;
        res_valid = 1'b1; res_pc = 64'h300; res_taken = 1'b1;
        pred_valid = 1'b1; pred_pc = 64'hDEAD; pred_meta = 20'hDEAD;
        step();
        tests_run++;
        if (upd_valid !== 1'b1 || upd_pc !== 64'h300 || upd_meta !== 20'd32 || count !== 4'd0) begin
            tests_failed++;
            $display("FAIL flush_head got v=%b pc=%h meta=%h cnt=%0d want v=1 pc=300 meta=20 cnt=0",
                     upd_valid, upd_pc, upd_meta, count);
        end
        idle();
        step();
        tests_run++;
        if (upd_valid !== 1'b0 || count !== 4'd0) begin
            tests_failed++; $display("FAIL flush_after got v=%b cnt=%0d want 0/0", upd_valid, count);
        end
        push_one(64'h500, 1'b0, 20'h5);
        resolve_one(64'h500, 1'b0);
        tests_run++;
        if (upd_pc !== 64'h500 || error !== 1'b0) begin
            tests_failed++; $display("FAIL flush_refill got pc=%h err=%b want 500/0", upd_pc, error);
        end
    endtask

    task automatic test_debug();
        do_reset();
        for (int i = 0; i < 3; i++) push_one(64'h600 + 64'(4 * i), 1'b0, 20'(i));
        for (int i = 0; i < 2; i++) begin
            idle();
            dbg = 1'b1; res_valid = 1'b1; res_pc = exp_q[0].pc; res_taken = 1'b1;
            step();
            tests_run++;
            if (upd_valid !== 1'b0 || count !== 4'(2 - i) || error !== 1'b0) begin
                tests_failed++;
                $display("FAIL debug%0d got v=%b cnt=%0d err=%b want 0/%0d/0", i, upd_valid, count, error, 2 - i);
            end
        end
        resolve_one(64'h608, 1'b0);
        tests_run++;
        if (upd_valid !== 1'b1 || upd_pc !== 64'h608) begin
            tests_failed++; $display("FAIL debug_exit got v=%b pc=%h want 1/608", upd_valid, upd_pc);
        end
    endtask

    task automatic test_errors();
        do_reset();
        resolve_one(64'h0, 1'b1);
        tests_run++;
        if (upd_valid !== 1'b0 || error !== 1'b1) begin
            tests_failed++; $display("FAIL empty_resolve got v=%b err=%b want 0/1", upd_valid, error);
        end
        for (int i = 0; i < 3; i++) step();
        tests_run++;
        if (error !== 1'b1) begin tests_failed++; $display("FAIL error_sticky got %b want 1", error); end
        do_reset();
        push_one(64'h100, 1'b1, 20'h7);
        resolve_one(64'h200, 1'b1);
        tests_run++;
        if (upd_valid !== 1'b1 || upd_pc !== 64'h100 || error !== 1'b1 || count !== 4'd0) begin
            tests_failed++;
            $display("FAIL pc_mismatch got v=%b pc=%h err=%b cnt=%0d want 1/100/1/0", upd_valid, upd_pc, error, count);
        end
    endtask

    task automatic test_stats();
        logic pt [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic at [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) push_one(64'h700 + 64'(4 * i), pt[i], 20'(i));
        for (int i = 0; i < 5; i++) resolve_one(64'h700 + 64'(4 * i), at[i]);
`ifdef BHT_UPD_STATS_EN
        tests_run++;
        if (resolved_cnt !== 32'd5 || mispred_cnt !== 32'd2) begin
            tests_failed++; $display("FAIL stats got %0d/%0d want 5/2", resolved_cnt, mispred_cnt);
        end
        tests_run++;
        if (s_resolved !== 2'd3 || s_mispred !== 2'd2) begin
            tests_failed++; $display("FAIL stats_sat got %0d/%0d want 3/2", s_resolved, s_mispred);
        end
`else
        tests_run++;
        if (resolved_cnt !== '0 || mispred_cnt !== '0 || s_resolved !== '0 || s_mispred !== '0) begin
            tests_failed++;
            $display("FAIL stats_off got %0d/%0d/%0d/%0d want 0", resolved_cnt, mispred_cnt, s_resolved, s_mispred);
        end
`endif
    endtask

    task automatic test_random();
        logic [CNT_W-1:0] exp_res, exp_mis;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            idle();
            pred_valid = ($urandom_range(0, 99) < 55);
            pred_pc    = {$urandom, $urandom};
            pred_taken = 1'($urandom_range(0, 1));
            pred_meta  = 20'($urandom);
            res_valid  = ($urandom_range(0, 99) < 45);
            res_taken  = 1'($urandom_range(0, 1));
            res_pc     = (exp_q.size() > 0 && $urandom_range(0, 31) != 0) ? exp_q[0].pc : {$urandom, $urandom};
            flush      = ($urandom_range(0, 99) < 3);
            dbg        = ($urandom_range(0, 99) < 10);
            step();
            tests_run++;
            if (upd_valid !== e_valid || count !== 4'(exp_q.size()) || error !== e_err
                || pred_ready !== (exp_q.size() < DEPTH)) begin
                tests_failed++;
                $display("FAIL rand%0d_ctrl got v=%b cnt=%0d err=%b rdy=%b want v=%b cnt=%0d err=%b",
                         n, upd_valid, count, error, pred_ready, e_valid, exp_q.size(), e_err);
            end
            if (e_valid) begin
                tests_run++;
                if (upd_pc !== e_pc || upd_taken !== e_taken || upd_meta !== e_meta) begin
                    tests_failed++;
                    $display("FAIL rand%0d_data got pc=%h t=%b meta=%h want pc=%h t=%b meta=%h",
                             n, upd_pc, upd_taken, upd_meta, e_pc, e_taken, e_meta);
                end
            end
        end
`ifdef BHT_UPD_STATS_EN
        exp_res = CNT_W'(e_res);
        exp_mis = CNT_W'(e_mis);
`else
        exp_res = '0;
        exp_mis = '0;
`endif
        tests_run++;
        if (resolved_cnt !== exp_res || mispred_cnt !== exp_mis) begin
            tests_failed++;
            $display("FAIL rand_stats got %0d/%0d want %0d/%0d", resolved_cnt, mispred_cnt, exp_res, exp_mis);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_full_wrap();
        test_flush();
        test_debug();
        test_errors();
        test_stats();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bht_update_queue.md
Name: bht_update_queue

Overview:
- Speculative branch-metadata queue that drives the update side of the tournament predictor.
- Fetch side: captures each prediction (PC, predicted direction, predictor metadata: gindex, gbp_valid/taken, lindex, lbp_valid/taken) into an in-order FIFO.
- Resolve side: the execute stage resolves branches in program order. The head entry pops and is re-emitted one cycle later as a registered bht_update carrying the original metadata, so the predictor trains the exact table entries it read.
- Sits between the frontend prediction path and the tournament predictor's bht_update_i.

Parameters:
- DEPTH, 8, queue entries; power of two, ≥2.
- VLEN, 64, virtual PC width.
- META_W, 20, flattened bp_metadata width: GlobalPredictorIndexBits + LocalPredictorIndexBits + 4.
- CNT_W, 32, width of statistics counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  squash all queued (wrong-path) entries.
- debug_mode_i  in  1  suppress predictor training.
- pred_valid_i  in  1  push a prediction.
- pred_ready_o  out  1  queue can accept a push (= !full).
- pred_pc_i  in  VLEN  PC of predicted branch.
- pred_taken_i  in  1  predicted direction.
- pred_meta_i  in  META_W  predictor metadata.
- resolve_valid_i  in  1  oldest outstanding branch resolved.
- resolve_pc_i  in  VLEN  PC of resolved branch.
- resolve_taken_i  in  1  actual direction.
- bht_update_valid_o  out  1  update strobe to predictor.
- bht_update_pc_o  out  VLEN  update PC (queued PC).
- bht_update_taken_o  out  1  actual direction.
- bht_update_meta_o  out  META_W  queued metadata.
- count_o  out  $clog2(DEPTH)+1  occupancy.
- error_o  out  1  sticky protocol error.
- resolved_cnt_o  out  CNT_W  resolved branches (optional feature).
- mispred_cnt_o  out  CNT_W  mispredictions (optional feature).

Behaviour:
Reset (rst_i high at a clock edge):
- count_o=0, pointers=0, pred_ready_o=1.
- All bht_update_*_o=0, error_o=0, counters=0.
- Reset mid-operation discards all entries. No update is emitted in the cycle after reset.

Storage:
- Circular FIFO with read/write pointers of $clog2(DEPTH) bits that wrap DEPTH-1→0.
- Separate count register; full = (count==DEPTH), empty = (count==0).

Push:
- Accepted when pred_valid_i && pred_ready_o && !flush_i.
- pred_ready_o depends only on registered count. A push at full is not accepted, even if a resolve occurs in the same cycle.

Pop:
- Occurs when resolve_valid_i && !empty.
- Next cycle: bht_update_valid_o = !debug_mode_i (sampled in the pop cycle); pc/meta from the head entry; taken = resolve_taken_i.
- Output registers hold their last value when valid=0.

Latency and count:
- Latency: resolve → update is exactly 1 cycle.
- Back-to-back resolves give back-to-back updates.
- Simultaneous push and pop: count unchanged, both take effect.

Errors:
- Resolve when empty: ignored, no update, error_o set.
- resolve_pc_i ≠ head PC: entry still pops, update still emitted, error_o set.
- error_o clears only on reset.

Flush:
- Resolve in the same cycle is processed first (update emitted next cycle).
- Then all entries are discarded: count=0, rptr=wptr. A push in the flush cycle is dropped.

Debug mode:
- Entries still pop.
- Only the update strobe is suppressed.

Optional Feature:
- Macro BHT_UPD_STATS_EN.
- Defined:
  - resolved_cnt_o increments on every pop.
  - mispred_cnt_o increments on a pop where resolve_taken_i ≠ stored pred_taken.
  - Both saturate at 2^CNT_W-1, count in debug mode too, and are unaffected by flush. Only reset clears them.
- Undefined:
  - No pred_taken storage, no counters.
  - resolved_cnt_o and mispred_cnt_o are tied to 0.

Test Plan:
- Reset then 3 pushes (pc 0x100/0x104/0x108, meta 0x0A5A1/0x00002/0x00003), 3 resolves taken=1/0/1 → updates on consecutive cycles, each 1 cycle after its resolve, with pc 0x100/0x104/0x108, taken 1/0/1, matching meta; count_o 3→0.
- Push 8 entries (DEPTH=8) → pred_ready_o=0, count_o=8. A 9th push plus a simultaneous resolve leaves count_o=7 and drops the 9th push. Push 4 more to force pointer wrap, drain all → PCs in order, no error.
- 4 entries queued; flush_i with simultaneous resolve and push → one update for the head, count_o=0 next cycle, pushed entry never emitted.
- debug_mode_i=1 during 2 resolves → bht_update_valid_o stays 0, count_o decrements by 2, error_o=0.
- Resolve on empty queue → no update, error_o=1 and stays set. Resolve with pc 0x200 vs head 0x100 → update pc=0x100 emitted, error_o=1.
- BHT_UPD_STATS_EN defined: 5 resolves with 2 direction mismatches → resolved_cnt_o=5, mispred_cnt_o=2. With CNT_W=2 and 5 resolves → resolved_cnt_o saturates at 3. Undefined → both 0.
